// File: rtl/apb_uart_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// One transfer at a time: IDLE -> SETUP -> ACCESS (wait states, timeout) -> RESP.
module apb_uart_arbiter #(
  parameter int APB_ADDR_WIDTH = 8,
  parameter int APB_DATA_WIDTH = 8,
  parameter int TIMEOUT        = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic [1:0]                  req_valid,
  input  logic [1:0]                  req_write,
  input  logic [2*APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [2*APB_DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]                  req_ready,
  output logic [1:0]                  rsp_valid,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        PSEL,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [APB_ADDR_WIDTH-1:0]   PADDR,
  output logic [APB_DATA_WIDTH-1:0]   PWDATA,
  input  logic [APB_DATA_WIDTH-1:0]   PRDATA,
  input  logic                        PREADY,
  input  logic                        PSLVERR,
  output logic [1:0]                  fsm_state
);

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Handshake: a requester holds req_valid and its fields until it sees a
  // one-cycle req_ready pulse; completion is a one-cycle rsp_valid pulse.
  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [7:0]      wait_q, wait_d;
  logic            pick;
  logic [1:0]      grant_oh;
  logic            psel_d, penable_d, pwrite_d, rsp_err_d, busy_d;
  logic [AW-1:0]   paddr_d;
  logic [DW-1:0]   pwdata_d, rsp_rdata_d;
  logic [1:0]      req_ready_d, rsp_valid_d;

  assign fsm_state = state_q;
  assign grant_oh  = grant_q ? 2'b10 : 2'b01;

  // On contention the requester not granted last time wins.
  always_comb begin
    if (req_valid == 2'b11) pick = ~last_q;
    else                    pick = req_valid[1];
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    wait_d      = wait_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    req_ready_d = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d     = SETUP;
          grant_d     = pick;
          last_d      = pick;
          pwrite_d    = req_write[pick];
          paddr_d     = pick ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
          pwdata_d    = pick ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
          psel_d      = 1'b1;
          req_ready_d = pick ? 2'b10 : 2'b01;
          wait_d      = 8'd0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        wait_d    = 8'd0;
      end
      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        // PREADY wins over a timeout firing in the same cycle.
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_oh;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = grant_oh;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      wait_q    <= 8'd0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      req_ready <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Directed bench for apb_uart_arbiter: single transfers, wait states, timeout,
// slave error, round-robin contention and reset during ACCESS.
module tb_apb_uart_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, busy, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  apb_uart_arbiter #(.APB_ADDR_WIDTH(8), .APB_DATA_WIDTH(8), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .fsm_state(fsm_state)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    cycle();
    cycle();
    PRESET = 1'b0;
  endtask

  // One requester issues one transfer; slave raises PREADY in ACCESS cycle wait_n
  // (0-based, -1 = never). Called and returns at a negedge with the DUT idle.
  task automatic run_xfer(input int req, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] prdata,
                          input logic slverr, input int wait_n,
                          input logic [1:0] exp_ready, input logic [7:0] exp_rdata,
                          input logic exp_err, input int exp_access);
    int n;
    req_valid = (req == 0) ? 2'b01 : 2'b10;
    req_write[req] = wr;
    req_addr[req*8 +: 8] = addr;
    req_wdata[req*8 +: 8] = wdata;
    PRDATA = prdata;
    PSLVERR = slverr;
    PREADY = 1'b0;
    cycle();
    check("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
    check("setup_req_ready", req_ready, exp_ready);
    check("setup_paddr", PADDR, addr);
    check("setup_pwdata", PWDATA, wdata);
    check("setup_pwrite", PWRITE, wr);
    check("setup_busy", busy, 1'b1);
    req_valid = 2'b00;
    cycle();
    n = 0;
    while (PENABLE === 1'b1 && n < 40) begin
      check("access_stable", {PSEL, PWRITE, PADDR, PWDATA}, {1'b1, wr, addr, wdata});
      PREADY = (n == wait_n);
      cycle();
      n++;
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    check("access_cycles", n, exp_access);
    check("resp_psel_penable", {PSEL, PENABLE}, 2'b00);
    check("resp_valid", rsp_valid, exp_ready);
    check("resp_rdata", rsp_rdata, exp_rdata);
    check("resp_err", rsp_err, exp_err);
    cycle();
    check("idle_rsp_valid", rsp_valid, 2'b00);
    check("idle_busy", busy, 1'b0);
    check("hold_rdata", rsp_rdata, exp_rdata);
    check("hold_err", rsp_err, exp_err);
  endtask

  initial begin
    PRESET = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge PCLK);
    check("rst_ctrl", {PSEL, PENABLE, PWRITE, busy, rsp_err}, 5'b0);
    check("rst_handshake", {req_ready, rsp_valid}, 4'b0);
    check("rst_data", {PADDR, PWDATA, rsp_rdata}, 24'h0);
    check("rst_state", fsm_state, 2'd0);
    cycle();
    PRESET = 1'b0;
    cycle();

    // single write, PREADY on first ACCESS cycle
    run_xfer(0, 1'b1, 8'h30, 8'h83, 8'hEE, 1'b0, 0, 2'b01, 8'h00, 1'b0, 1);
    // read from requester 1, PREADY in third ACCESS cycle
    run_xfer(1, 1'b0, 8'h50, 8'h00, 8'h0A, 1'b0, 2, 2'b10, 8'h0A, 1'b0, 3);
    // PREADY on the very cycle the timeout would fire: normal completion
    run_xfer(0, 1'b0, 8'h44, 8'h00, 8'h5C, 1'b0, 15, 2'b01, 8'h5C, 1'b0, 16);
    // PREADY never: abort after 16 ACCESS cycles, rdata forced to zero
    run_xfer(1, 1'b0, 8'h60, 8'h00, 8'hFF, 1'b0, -1, 2'b10, 8'h00, 1'b1, 16);
    // slave error on a write
    run_xfer(0, 1'b1, 8'h70, 8'h11, 8'h00, 1'b1, 0, 2'b01, 8'h00, 1'b1, 1);

    // contention from reset: grants alternate starting with requester 0
    do_reset();
    req_valid = 2'b11; req_write = 2'b11; req_addr = 16'h2010; req_wdata = 16'hB0A0;
    PREADY = 1'b1;
    exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      cycle();
      if (req_ready != 2'b00) check("rr_grant", req_ready, exp_q.pop_front());
    end
    check("rr_grants_seen", exp_q.size(), 0);
    req_valid = 2'b00;
    repeat (4) cycle();
    PREADY = 1'b0;
    check("rr_back_idle", busy, 1'b0);

    // reset during ACCESS of a requester-0 transfer
    req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h0022;
    cycle();
    req_valid = 2'b00;
    cycle();
    cycle();
    check("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    #1;
    check("async_rst_psel_penable", {PSEL, PENABLE}, 2'b00);
    check("async_rst_busy", busy, 1'b0);
    cycle();
    PRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("no_rsp_after_rst", rsp_valid, 2'b00);
    end
    req_valid = 2'b11;
    cycle();
    check("post_rst_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    PREADY = 1'b1;
    repeat (4) cycle();
    PREADY = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
